// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared opcodes, state encodings and datapath-control encodings for the multicycle control unit
package mcu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_NONE
    } iclass_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_IMM = 2'b10;
    localparam logic [1:0] MTR_PC4 = 2'b11;

    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_S  = 3'b001;
    localparam logic [2:0] IMM_B  = 3'b010;
    localparam logic [2:0] IMM_UJ = 3'b100;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - instruction and data memory request/ready handshake bundle
interface multicycle_control_unit_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        input  imem_ready,
        output dmem_req,
        output dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        input  dmem_req,
        input  dmem_we,
        output dmem_ready
    );
endinterface

// File: rtl/mcu_decode.sv
// rtl/mcu_decode.sv - combinational opcode classifier with illegal-opcode flag
module mcu_decode
    import mcu_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_e    iclass,
    output logic       illegal
);
    always_comb begin
        iclass  = CLS_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_R:      iclass = CLS_R;
            OP_I:      iclass = CLS_I;
            OP_LOAD:   iclass = CLS_LOAD;
            OP_STORE:  iclass = CLS_STORE;
            OP_BRANCH: iclass = CLS_BRANCH;
            OP_LUI:    iclass = CLS_LUI;
            OP_AUIPC:  iclass = CLS_AUIPC;
            OP_JAL:    iclass = CLS_JAL;
            OP_JALR:   iclass = CLS_JALR;
            default:   illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle control FSM with timed memory handshakes; MCU_TRAP_EN enables the TRAP state
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [6:0]                       opcode,
    input  logic                             branch_taken,
    multicycle_control_unit_if.master        mem,
    output logic                             IR_Write,
    output logic                             PC_Write,
    output logic                             A_Sel,
    output logic                             B_Sel,
    output logic [1:0]                       ALU_Op,
    output logic [1:0]                       PcSrc,
    output logic                             RegWrite,
    output logic                             MemWrite,
    output logic [1:0]                       MemtoReg,
    output logic [2:0]                       ImmSrc,
    output logic [2:0]                       state_o,
    output logic                             mem_timeout,
    output logic                             trap
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    iclass_e          iclass;
    logic             illegal;
    logic             req_now, ready_now, timeout_hit, is_store;

    mcu_decode u_decode (
        .opcode  (opcode),
        .iclass  (iclass),
        .illegal (illegal)
    );

    assign is_store = (iclass == CLS_STORE);

    // Ready is only meaningful for the handshake owned by the current state.
    always_comb begin
        req_now     = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
        ready_now   = (state_q == ST_FETCH)  ? mem.imem_ready :
                      (state_q == ST_MEMORY) ? mem.dmem_ready : 1'b0;
        timeout_hit = req_now && !ready_now && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:     if (ready_now) state_d = ST_DECODE;
`ifdef MCU_TRAP_EN
            ST_DECODE:    state_d = illegal ? ST_TRAP : ST_EXECUTE;
`else
            ST_DECODE:    state_d = illegal ? ST_FETCH : ST_EXECUTE;
`endif
            ST_EXECUTE: begin
                case (iclass)
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    CLS_BRANCH:          state_d = ST_FETCH;
                    default:             state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY:    if (ready_now) state_d = is_store ? ST_FETCH : ST_WRITEBACK;
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase
`ifdef MCU_TRAP_EN
        if (timeout_hit) state_d = ST_TRAP;
`endif
    end

    // Counter saturates at the timeout point so a long wait cannot wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (req_now && !ready_now && (cnt_q != CNT_W'(TIMEOUT_CYCLES - 1)))
            cnt_d = cnt_q + CNT_W'(1);
        if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEMORY)))
            cnt_d = '0;
        timeout_d = timeout_q | timeout_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        IR_Write     = 1'b0;
        PC_Write     = 1'b0;
        A_Sel        = 1'b0;
        B_Sel        = 1'b0;
        ALU_Op       = ALU_ADD;
        PcSrc        = PC_SEQ;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        MemtoReg     = MTR_ALU;
        ImmSrc       = IMM_I;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem.imem_req = 1'b1;
                    IR_Write     = mem.imem_ready;
                end
`ifndef MCU_TRAP_EN
                ST_DECODE: PC_Write = illegal;
`endif
                ST_EXECUTE: begin
                    A_Sel = (iclass == CLS_AUIPC) || (iclass == CLS_JAL);
                    B_Sel = (iclass != CLS_R) && (iclass != CLS_BRANCH);
                    case (iclass)
                        CLS_R:      ALU_Op = ALU_R;
                        CLS_I:      ALU_Op = ALU_I;
                        CLS_BRANCH: ALU_Op = ALU_BR;
                        default:    ALU_Op = ALU_ADD;
                    endcase
                    case (iclass)
                        CLS_STORE:                   ImmSrc = IMM_S;
                        CLS_BRANCH:                  ImmSrc = IMM_B;
                        CLS_LUI, CLS_AUIPC, CLS_JAL: ImmSrc = IMM_UJ;
                        default:                     ImmSrc = IMM_I;
                    endcase
                    if (iclass == CLS_BRANCH) begin
                        PC_Write = 1'b1;
                        PcSrc    = branch_taken ? PC_TARGET : PC_SEQ;
                    end
                end
                ST_MEMORY: begin
                    mem.dmem_req = 1'b1;
                    mem.dmem_we  = is_store;
                    MemWrite     = is_store;
                    PC_Write     = is_store && mem.dmem_ready;
                end
                ST_WRITEBACK: begin
                    RegWrite = 1'b1;
                    PC_Write = 1'b1;
                    case (iclass)
                        CLS_LOAD:          MemtoReg = MTR_MEM;
                        CLS_LUI:           MemtoReg = MTR_IMM;
                        CLS_JAL, CLS_JALR: MemtoReg = MTR_PC4;
                        default:           MemtoReg = MTR_ALU;
                    endcase
                    PcSrc = (iclass == CLS_JALR) ? PC_JALR :
                            (iclass == CLS_JAL)  ? PC_TARGET : PC_SEQ;
                end
                default: ;
            endcase
        end
    end

    assign state_o     = state_q;
    assign mem_timeout = timeout_q;
`ifdef MCU_TRAP_EN
    assign trap = rst_n && (state_q == ST_TRAP);
`else
    assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized instruction stream against a phase-sequence reference model
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       IR_Write, PC_Write, A_Sel, B_Sel, RegWrite, MemWrite;
    logic [1:0] ALU_Op, PcSrc, MemtoReg;
    logic [2:0] ImmSrc, state_o;
    logic       mem_timeout, trap;
    int         n_tests = 0;
    int         n_fail  = 0;

    multicycle_control_unit_if mif();

    multicycle_control_unit #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem(mif.master),
        .IR_Write(IR_Write), .PC_Write(PC_Write), .A_Sel(A_Sel), .B_Sel(B_Sel),
        .ALU_Op(ALU_Op), .PcSrc(PcSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ImmSrc(ImmSrc), .state_o(state_o),
        .mem_timeout(mem_timeout), .trap(trap)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] R = 7'h33, I = 7'h13, LW = 7'h03, SW = 7'h23, BR = 7'h63;
    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67;

    function automatic logic [17:0] ctl_now();
        return {mif.imem_req, mif.dmem_req, mif.dmem_we, IR_Write, PC_Write, A_Sel, B_Sel,
                ALU_Op, PcSrc, RegWrite, MemWrite, MemtoReg, ImmSrc};
    endfunction

    function automatic bit legal(logic [6:0] op);
        return op inside {R, I, LW, SW, BR, LUI, AUIPC, JAL, JALR};
    endfunction

    // Phase numbers: 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback.
    function automatic logic [17:0] exp_ctl(int ph, logic [6:0] op, logic bt, logic rdy);
        logic imr = 0, dmr = 0, we = 0, irw = 0, pcw = 0, as = 0, bs = 0, rw = 0, mw = 0;
        logic [1:0] alu = 0, pcs = 0, mtr = 0;
        logic [2:0] imm = 0;
        case (ph)
            0: begin imr = 1; irw = rdy; end
            1: pcw = !legal(op);
            2: begin
                as  = (op == AUIPC) || (op == JAL);
                bs  = (op != R) && (op != BR);
                alu = (op == R) ? 2'd2 : (op == I) ? 2'd3 : (op == BR) ? 2'd1 : 2'd0;
                imm = (op == SW) ? 3'd1 : (op == BR) ? 3'd2 :
                      (op == LUI || op == AUIPC || op == JAL) ? 3'd4 : 3'd0;
                if (op == BR) begin pcw = 1; pcs = bt ? 2'd1 : 2'd0; end
            end
            3: begin dmr = 1; we = (op == SW); mw = we; pcw = we && rdy; end
            4: begin
                rw = 1; pcw = 1;
                mtr = (op == LW) ? 2'd1 : (op == LUI) ? 2'd2 : (op == JAL || op == JALR) ? 2'd3 : 2'd0;
                pcs = (op == JALR) ? 2'd2 : (op == JAL) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        return {imr, dmr, we, irw, pcw, as, bs, alu, pcs, rw, mw, mtr, imm};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_state_imem_req", {29'd0, state_o}, 32'd0);
        check("release_imem_req", {31'd0, mif.imem_req}, 32'd1);
    endtask

    // bt_mode 0/1 forces branch_taken, 2 randomizes it each cycle.
    task automatic run_instr(string tag, logic [6:0] op, int li, int ld, int bt_mode);
        int   ph[$];
        int   kk[$];
        logic bt, rdy;
        for (int i = 0; i <= li; i++) begin ph.push_back(0); kk.push_back(i); end
        ph.push_back(1); kk.push_back(0);
        if (legal(op)) begin
            ph.push_back(2); kk.push_back(0);
            if (op == LW || op == SW)
                for (int i = 0; i <= ld; i++) begin ph.push_back(3); kk.push_back(i); end
            if (op != BR && op != SW) begin ph.push_back(4); kk.push_back(0); end
        end
        foreach (ph[j]) begin
            @(negedge clk);
            bt = (bt_mode == 2) ? 1'($urandom) : (bt_mode == 1);
            branch_taken   = bt;
            opcode         = (ph[j] == 0) ? 7'($urandom) : op;
            mif.imem_ready = 1'($urandom);
            mif.dmem_ready = 1'($urandom);
            if (ph[j] == 0) mif.imem_ready = (kk[j] == li);
            if (ph[j] == 3) mif.dmem_ready = (kk[j] == ld);
            rdy = (ph[j] == 0) ? mif.imem_ready : mif.dmem_ready;
            #1;
            check($sformatf("%s_c%0d_state", tag, j), {29'd0, state_o}, 32'(ph[j]));
            check($sformatf("%s_c%0d_ctl", tag, j), {14'd0, ctl_now()}, {14'd0, exp_ctl(ph[j], op, bt, rdy)});
        end
    endtask

    logic [6:0] pool [11] = '{R, I, LW, SW, BR, LUI, AUIPC, JAL, JALR, 7'h7f, 7'h00};

    initial begin
        int npool;
        mif.imem_ready = 1'b1;
        mif.dmem_ready = 1'b1;
        opcode = SW;
        #2;
        check("reset_ctl", {14'd0, ctl_now()}, 32'd0);
        check("reset_state", {29'd0, state_o}, 32'd0);
        check("reset_flags", {30'd0, mem_timeout, trap}, 32'd0);
        do_reset();

        run_instr("add", R, 0, 0, 2);
        run_instr("lw", LW, 2, 3, 2);
        run_instr("beq_taken", BR, 1, 0, 1);
        run_instr("beq_not", BR, 0, 0, 0);
        run_instr("sw", SW, 1, 2, 2);
        run_instr("jalr", JALR, 0, 0, 2);
`ifndef MCU_TRAP_EN
        run_instr("illegal_7f", 7'h7f, 1, 0, 2);
        npool = 11;
`else
        npool = 9;
`endif
        for (int n = 0; n < 40; n++)
            run_instr($sformatf("rnd%0d", n), pool[$urandom_range(npool - 1)],
                      $urandom_range(6), $urandom_range(6), 2);
        check("no_timeout_in_stream", {31'd0, mem_timeout}, 32'd0);

        do_reset();
        repeat (15) @(posedge clk);
        #1 check("timeout_before_16", {31'd0, mem_timeout}, 32'd0);
        @(posedge clk);
        #1 check("timeout_at_16", {31'd0, mem_timeout}, 32'd1);
        repeat (10) @(posedge clk);
        #1 check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
`ifdef MCU_TRAP_EN
        check("timeout_trap_state", {29'd0, state_o}, 32'd5);
        check("timeout_trap_flag", {31'd0, trap}, 32'd1);
`else
        check("timeout_wait_continues", {28'd0, state_o, mif.imem_req}, {28'd0, 3'd0, 1'b1});
        @(negedge clk) mif.imem_ready = 1'b1;
        @(posedge clk);
        #1 check("timeout_then_fetch_done", {29'd0, state_o}, 32'd1);
        check("timeout_flag_no_trap", {31'd0, trap}, 32'd0);

        do_reset();
`endif

`ifdef MCU_TRAP_EN
        do_reset();
        @(negedge clk) mif.imem_ready = 1'b1;
        @(negedge clk) begin mif.imem_ready = 1'b0; opcode = 7'h7f; end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            mif.imem_ready = 1'($urandom);
            mif.dmem_ready = 1'($urandom);
            #1 check($sformatf("trap_hold_c%0d", c), {10'd0, state_o, trap, ctl_now()},
                     {10'd0, 3'd5, 1'b1, 18'd0});
        end
        do_reset();
`endif

        run_instr("sw_pre_reset", SW, 0, 0, 2);
        @(negedge clk);
        opcode = 7'($urandom);
        mif.imem_ready = 1'b1;
        @(negedge clk);
        opcode = SW;
        mif.imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mif.dmem_ready = 1'b0;
        #1 check("sw_in_memory", {28'd0, state_o, MemWrite}, {28'd0, 3'd3, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("midmem_reset_outputs", {28'd0, mif.dmem_req, MemWrite, mif.dmem_we, PC_Write},
                 32'd0);
        check("midmem_reset_state", {29'd0, state_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("post_release", {28'd0, state_o, mif.imem_req}, {28'd0, 3'd0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max wait cycles on any memory handshake before timeout (2..255).
REQ-002 SHALL have parameter CNT_W, default 8: width of the wait counter.
REQ-003 SHALL have port clk  in  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port opcode  in  7  instruction[6:0] from the external instruction register.
REQ-006 SHALL have port branch_taken  in  1  comparator result, valid in EXECUTE.
REQ-007 SHALL have ports imem_req out 1 and imem_ready in 1: instruction-fetch handshake.
REQ-008 SHALL have ports dmem_req out 1, dmem_we out 1 and dmem_ready in 1: data-memory handshake.
REQ-009 SHALL have outputs IR_Write 1, PC_Write 1, A_Sel 1, B_Sel 1, ALU_Op 2, PcSrc 2, RegWrite 1, MemWrite 1, MemtoReg 2, ImmSrc 3: datapath controls.
REQ-010 SHALL have outputs state_o 3 (current state), mem_timeout 1 (sticky), trap 1 (sticky).

Function
REQ-011 SHALL implement the states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4 and TRAP=5; all outputs SHALL be decoded from the registered state plus opcode and branch_taken.
REQ-012 FETCH: imem_req=1 until imem_ready is sampled high; on that edge, IR_Write SHALL pulse for 1 cycle and the next state SHALL be DECODE.
REQ-013 DECODE SHALL last exactly 1 cycle and then go to EXECUTE; for an illegal opcode, the behaviour is defined in REQ-024.
REQ-014 EXECUTE: A_Sel, B_Sel, ALU_Op and ImmSrc SHALL use the single-cycle encodings (ALU_Op 00 add, 01 branch/sub, 10 R, 11 I; ImmSrc 000 I, 001 S, 010 B, 100 U/J).
REQ-015 After EXECUTE, loads and stores SHALL go to MEMORY; R, I, LUI, AUIPC, JAL and JALR SHALL go to WRITEBACK; branches SHALL go to FETCH.
REQ-016 Branch in EXECUTE: PC_Write=1 for 1 cycle; PcSrc=01 if branch_taken, else 00; RegWrite=0.
REQ-017 MEMORY: dmem_req SHALL be held at 1 until dmem_ready is sampled high; dmem_we=MemWrite=1 for stores only; a store SHALL then go to FETCH with PC_Write=1 and PcSrc=00; a load SHALL go to WRITEBACK.
REQ-018 WRITEBACK SHALL assert RegWrite=1 and PC_Write=1 for exactly 1 cycle; MemtoReg SHALL be 01 for loads, 10 for LUI, 11 for JALR/JAL, else 00; PcSrc SHALL be 10 for JALR, 01 for JAL, else 00; next state FETCH.
REQ-019 The ready inputs SHALL be ignored while the matching req is 0; a ready already high in the first req cycle SHALL complete in that cycle.
REQ-020 The wait counter SHALL clear on entering FETCH or MEMORY and increment each cycle that req=1 and ready=0.
REQ-021 When the counter reaches TIMEOUT_CYCLES-1 with ready still 0, mem_timeout SHALL set and stay set until reset.
REQ-022 RegWrite, PC_Write, IR_Write and MemWrite SHALL never be asserted in TRAP or during reset.

Reset
REQ-023 When rst_n=0, all outputs SHALL be 0 immediately, state SHALL be FETCH, the counter SHALL be 0 and the sticky flags SHALL clear; imem_req SHALL rise in the first cycle after release; a handshake in progress when reset asserts SHALL be abandoned.

Configuration
REQ-024 Macro MCU_TRAP_EN defined: an illegal opcode in DECODE or a timeout SHALL go to TRAP; trap=1 and the FSM SHALL hold there until reset.
REQ-025 MCU_TRAP_EN undefined: an illegal opcode SHALL retire as a NOP (PC_Write=1, PcSrc=00, go to FETCH); a timeout SHALL set only mem_timeout and the wait SHALL continue; trap SHALL be tied to 0.

Structure
REQ-026 Package mcu_pkg SHALL hold the opcode constants (R, I, load, S, B, LUI, AUIPC, JAL, JALR), the state encodings, and the ALU_Op, PcSrc, MemtoReg and ImmSrc encodings.
REQ-027 The opcode classification SHALL be a purely combinational sub-module mcu_decode (opcode in, instruction class plus illegal flag out), instantiated once.

Verification
REQ-028 ADD (0110011), imem_ready high in the first req cycle -> state sequence 0,1,2,4,0; ALU_Op=10 in EXECUTE; RegWrite=1 for 1 cycle.
REQ-029 LW (0000011), dmem_ready high 3 cycles after req -> MEMORY lasts 4 cycles; WRITEBACK has MemtoReg=01 and RegWrite=1 for 1 cycle.
REQ-030 BEQ (1100011), branch_taken=1 -> PC_Write=1 and PcSrc=01 in EXECUTE; no MEMORY or WRITEBACK state; RegWrite stays 0.
REQ-031 Opcode 1111111 -> with MCU_TRAP_EN: state 5, trap=1 held for 100 cycles; without it: PC_Write=1, PcSrc=00, back to FETCH.
REQ-032 imem_ready held at 0, TIMEOUT_CYCLES=16 -> mem_timeout=1 on the 16th wait cycle and stays 1.
REQ-033 rst_n pulled low mid-MEMORY for SW -> dmem_req=0 and MemWrite=0 at once; after release, state_o=0 and imem_req=1.
